culsans_region_attr: RTL and testbench

Runtime-programmable memory-attribute lookup unit for the Culsans SoC. It replaces the fixed cached, shared, executable and non-idempotent region rules with a table of `NrRules` software-writable entries. Each incoming request address is classified and returned through a buffered valid/ready pipeline. It sits between each core's request path and the ACE interconnect, and drives the AxDOMAIN/AxCACHE selection and the PMA checks.

---
 rtl/culsans_region_attr.sv | 193 +++++++++++++++++++
 tb/tb_culsans_region_attr.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/culsans_region_attr.sv
// culsans_region_attr
// Runtime-programmable memory-attribute lookup. Software fills a table of
// NrRules {base, length, attr} entries; each request address is classified
// against the table and the result is returned through a 2-entry output FIFO.
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   cfg_we_i                  configuration write strobe
//   cfg_idx_i                 rule index
//   cfg_sel_i                 field select: 0 base, 1 length, 2 attr, 3 lock
//   cfg_wdata_i               write data; attr uses [4:0] = {en, nonidem, exec, cached, shared}
//   cfg_err_o                 one-cycle pulse after a rejected write
//   req_valid_i/req_ready_o   lookup request handshake
//   req_addr_i                address to classify
//   rsp_valid_o/rsp_ready_i   result handshake
//   rsp_addr_o                echoed request address
//   rsp_attr_o                resolved {nonidem, exec, cached, shared}
//   rsp_hit_o                 an enabled rule matched
//   rsp_idx_o                 matching rule index, 0 on a miss
//
// Build option: define CULSANS_REGION_LOCK_EN to add a sticky global lock
// (sel 3, wdata[0] = 1) that rejects every later write until reset.
module culsans_region_attr #(
    parameter int unsigned NrRules     = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter logic [3:0]  DefaultAttr = 4'b1000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_we_i,
    input  logic [3:0]           cfg_idx_i,
    input  logic [1:0]           cfg_sel_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_err_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [AddrWidth-1:0] rsp_addr_o,
    output logic [3:0]           rsp_attr_o,
    output logic                 rsp_hit_o,
    output logic [3:0]           rsp_idx_o
);

    localparam int unsigned IdxWidth      = 4;
    localparam int unsigned AttrWidth     = 4;
    localparam int unsigned RuleAttrWidth = 5;
    localparam int unsigned FifoDepth     = 2;
    localparam int unsigned CntWidth      = 2;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [AttrWidth-1:0] attr;
        logic                 hit;
        logic [IdxWidth-1:0]  idx;
    } rsp_t;

    logic [AddrWidth-1:0]     base_q [NrRules];
    logic [AddrWidth-1:0]     len_q  [NrRules];
    logic [RuleAttrWidth-1:0] attr_q [NrRules];

    logic idx_ok_c;
    logic cfg_apply_c;
    logic cfg_err_q;

    assign idx_ok_c = 32'(cfg_idx_i) < NrRules;

`ifdef CULSANS_REGION_LOCK_EN
    logic lock_q;

    assign cfg_apply_c = cfg_we_i && idx_ok_c && !lock_q;

    // Sticky lock, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q <= 1'b0;
        end else if (cfg_apply_c && (cfg_sel_i == 2'd3) && cfg_wdata_i[0]) begin
            lock_q <= 1'b1;
        end
    end
`else
    assign cfg_apply_c = cfg_we_i && idx_ok_c && (cfg_sel_i != 2'd3);
`endif

    // Rule table
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
                attr_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                if (cfg_apply_c && (cfg_idx_i == IdxWidth'(i))) begin
                    case (cfg_sel_i)
                        2'd0:    base_q[i] <= cfg_wdata_i;
                        2'd1:    len_q[i]  <= cfg_wdata_i;
                        2'd2:    attr_q[i] <= cfg_wdata_i[RuleAttrWidth-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Rejected-write pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_we_i && !cfg_apply_c;
        end
    end

    assign cfg_err_o = cfg_err_q;

    // Per-rule match; end address summed one bit wider so top-of-space regions don't wrap
    logic [NrRules-1:0] match_c;

    always_comb begin
        match_c = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            match_c[i] = attr_q[i][RuleAttrWidth-1]
                      && (req_addr_i >= base_q[i])
                      && ({1'b0, req_addr_i} < ({1'b0, base_q[i]} + {1'b0, len_q[i]}));
        end
    end

    // Priority resolve: scan high to low so the lowest matching index wins
    rsp_t lookup_c;

    always_comb begin
        lookup_c      = '0;
        lookup_c.addr = req_addr_i;
        lookup_c.attr = DefaultAttr;
        for (int i = int'(NrRules) - 1; i >= 0; i--) begin
            if (match_c[i]) begin
                lookup_c.hit  = 1'b1;
                lookup_c.idx  = IdxWidth'(i);
                lookup_c.attr = attr_q[i][AttrWidth-1:0];
            end
        end
        // Shared without cached is not coherent; drop shared in the result only
        if (!lookup_c.attr[1]) begin
            lookup_c.attr[0] = 1'b0;
        end
    end

    // 2-entry result FIFO
    rsp_t                fifo_q [FifoDepth];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                push_c;
    logic                pop_c;

    assign req_ready_o = count_q < CntWidth'(FifoDepth);
    assign rsp_valid_o = count_q != '0;
    assign push_c      = req_valid_i && req_ready_o;
    assign pop_c       = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < FifoDepth; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_c) begin
                fifo_q[wr_ptr_q] <= lookup_c;
                wr_ptr_q         <= !wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CntWidth'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CntWidth'(1);
            end
        end
    end

    assign rsp_addr_o = fifo_q[rd_ptr_q].addr;
    assign rsp_attr_o = fifo_q[rd_ptr_q].attr;
    assign rsp_hit_o  = fifo_q[rd_ptr_q].hit;
    assign rsp_idx_o  = fifo_q[rd_ptr_q].idx;

endmodule

// File: tb/tb_culsans_region_attr.sv
// Testbench for culsans_region_attr: directed scenarios followed by a random
// phase, all checked against a queue-based reference model of the table and
// output FIFO.
module tb_culsans_region_attr;

    localparam int         NR  = 4;
    localparam int         AW  = 64;
    localparam logic [3:0] DEF = 4'b1000;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic          cfg_we_i;
    logic [3:0]    cfg_idx_i;
    logic [1:0]    cfg_sel_i;
    logic [AW-1:0] cfg_wdata_i;
    logic          cfg_err_o;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [AW-1:0] rsp_addr_o;
    logic [3:0]    rsp_attr_o;
    logic          rsp_hit_o;
    logic [3:0]    rsp_idx_o;

    culsans_region_attr #(
        .NrRules     (NR),
        .AddrWidth   (AW),
        .DefaultAttr (DEF)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cfg_we_i    (cfg_we_i),
        .cfg_idx_i   (cfg_idx_i),
        .cfg_sel_i   (cfg_sel_i),
        .cfg_wdata_i (cfg_wdata_i),
        .cfg_err_o   (cfg_err_o),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_addr_o  (rsp_addr_o),
        .rsp_attr_o  (rsp_attr_o),
        .rsp_hit_o   (rsp_hit_o),
        .rsp_idx_o   (rsp_idx_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  attr;
        logic        hit;
        logic [3:0]  idx;
    } exp_t;

    exp_t        q[$];
    logic [63:0] m_base [NR];
    logic [63:0] m_len  [NR];
    logic [4:0]  m_attr [NR];
    bit          m_lock;
    bit          m_err;
    bit          last_acc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference classification: first enabled rule whose [base, base+len) holds the address
    function automatic exp_t model_lookup(input logic [63:0] a);
        exp_t        r;
        logic [64:0] lo;
        logic [64:0] hi;
        bit          found;
        r.addr = a;
        r.attr = DEF;
        r.hit  = 1'b0;
        r.idx  = 4'd0;
        found  = 0;
        for (int i = 0; i < NR; i++) begin
            lo = {1'b0, m_base[i]};
            hi = lo + {1'b0, m_len[i]};
            if (!found && m_attr[i][4] && ({1'b0, a} >= lo) && ({1'b0, a} < hi)) begin
                found = 1;
                r.hit  = 1'b1;
                r.idx  = 4'(i);
                r.attr = m_attr[i][3:0];
            end
        end
        if (r.attr[1] == 1'b0) r.attr[0] = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NR; i++) begin
            m_base[i] = '0;
            m_len[i]  = '0;
            m_attr[i] = '0;
        end
        m_lock = 0;
        m_err  = 0;
    endtask

    task automatic check_outputs();
        chk("req_ready", 64'(req_ready_o), 64'(q.size() < 2));
        chk("rsp_valid", 64'(rsp_valid_o), 64'(q.size() != 0));
        chk("cfg_err", 64'(cfg_err_o), 64'(m_err));
        if (q.size() != 0) begin
            chk("rsp_addr", rsp_addr_o, q[0].addr);
            chk("rsp_attr", 64'(rsp_attr_o), 64'(q[0].attr));
            chk("rsp_hit", 64'(rsp_hit_o), 64'(q[0].hit));
            chk("rsp_idx", 64'(rsp_idx_o), 64'(q[0].idx));
        end
    endtask

    // One clock: model sees the pre-edge table for lookups, then applies the write
    task automatic cycle();
        exp_t r;
        bit   acc;
        bit   pop;
        bit   err_n;
        int   ix;
        acc   = req_valid_i && (q.size() < 2);
        pop   = rsp_ready_i && (q.size() != 0);
        r     = model_lookup(req_addr_i);
        err_n = 0;
        if (cfg_we_i) begin
            ix    = int'(cfg_idx_i);
            err_n = (ix >= NR);
`ifdef CULSANS_REGION_LOCK_EN
            if (m_lock) err_n = 1;
`else
            if (cfg_sel_i == 2'd3) err_n = 1;
`endif
            if (!err_n) begin
                case (cfg_sel_i)
                    2'd0: m_base[ix] = cfg_wdata_i;
                    2'd1: m_len[ix]  = cfg_wdata_i;
                    2'd2: m_attr[ix] = cfg_wdata_i[4:0];
                    default: if (cfg_wdata_i[0]) m_lock = 1;
                endcase
            end
        end
        @(posedge clk_i);
        #1;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(r);
        m_err    = err_n;
        last_acc = acc;
        check_outputs();
    endtask

    task automatic idle();
        cfg_we_i    = 1'b0;
        cfg_idx_i   = 4'd0;
        cfg_sel_i   = 2'd0;
        cfg_wdata_i = '0;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic cfg_write(input logic [3:0] idx, input logic [1:0] sel, input logic [63:0] d);
        cfg_we_i    = 1'b1;
        cfg_idx_i   = idx;
        cfg_sel_i   = sel;
        cfg_wdata_i = d;
        req_valid_i = 1'b0;
        cycle();
        cfg_we_i = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] a);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        chk("accept_timeout", 64'(last_acc), 64'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic expect_head(input logic [3:0] attr, input logic hit, input logic [3:0] idx);
        chk("head_valid", 64'(rsp_valid_o), 64'd1);
        chk("head_attr", 64'(rsp_attr_o), 64'(attr));
        chk("head_hit", 64'(rsp_hit_o), 64'(hit));
        chk("head_idx", 64'(rsp_idx_o), 64'(idx));
    endtask

    task automatic apply_reset();
        idle();
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_attr", 64'(rsp_attr_o), 64'd0);
        chk("rst_hit", 64'(rsp_hit_o), 64'd0);
        chk("rst_idx", 64'(rsp_idx_o), 64'd0);
        chk("rst_addr", rsp_addr_o, 64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        idle();
        rsp_ready_i = 1'b1;
        #2;
        apply_reset();

        // Empty table: everything misses
        lookup(64'h8000_0000);
        expect_head(4'b1000, 1'b0, 4'd0);

        cfg_write(4'd1, 2'd0, 64'h8000_0000);
        cfg_write(4'd1, 2'd1, 64'h4000_0000);
        cfg_write(4'd1, 2'd2, 64'(5'b10111));
        cfg_write(4'd0, 2'd0, 64'h8004_0000);
        cfg_write(4'd0, 2'd1, 64'h0004_0000);
        cfg_write(4'd0, 2'd2, 64'(5'b10011));

        lookup(64'h8004_1000);
        expect_head(4'b0011, 1'b1, 4'd0);
        lookup(64'h8010_0000);
        expect_head(4'b0111, 1'b1, 4'd1);
        lookup(64'hC000_0000);
        expect_head(4'b1000, 1'b0, 4'd0);

        // Shared without cached resolves to not shared
        cfg_write(4'd2, 2'd0, 64'h1000_0000);
        cfg_write(4'd2, 2'd1, 64'h0000_1000);
        cfg_write(4'd2, 2'd2, 64'(5'b10101));
        lookup(64'h1000_0FFF);
        expect_head(4'b0100, 1'b1, 4'd2);
        lookup(64'h1000_1000);
        expect_head(4'b1000, 1'b0, 4'd0);

        // Region ending exactly at the top of the address space
        cfg_write(4'd3, 2'd0, 64'hFFFF_FFFF_FFFF_F000);
        cfg_write(4'd3, 2'd1, 64'h0000_0000_0000_1000);
        cfg_write(4'd3, 2'd2, 64'(5'b11111));
        lookup(64'hFFFF_FFFF_FFFF_FFF8);
        expect_head(4'b1111, 1'b1, 4'd3);
        lookup(64'h0);
        expect_head(4'b1000, 1'b0, 4'd0);
        cfg_write(4'd3, 2'd1, 64'h0);
        lookup(64'hFFFF_FFFF_FFFF_F000);
        expect_head(4'b1000, 1'b0, 4'd0);
        run(1);

        // Back-pressure: two fill the FIFO, the third stalls
        rsp_ready_i = 1'b0;
        lookup(64'h8004_0000);
        lookup(64'h8010_0000);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h0;
        cycle();
        chk("c_stalled", 64'(last_acc), 64'd0);
        chk("ready_low", 64'(req_ready_o), 64'd0);
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (last_acc) break;
        end
        chk("c_accept", 64'(last_acc), 64'd1);
        idle();
        run(4);

        // Write and lookup in the same cycle: lookup sees the old table
        cfg_we_i    = 1'b1;
        cfg_idx_i   = 4'd0;
        cfg_sel_i   = 2'd2;
        cfg_wdata_i = 64'(5'b00011);
        req_valid_i = 1'b1;
        req_addr_i  = 64'h8004_1000;
        cycle();
        chk("same_cycle_acc", 64'(last_acc), 64'd1);
        expect_head(4'b0011, 1'b1, 4'd0);
        idle();
        lookup(64'h8004_1000);
        expect_head(4'b0111, 1'b1, 4'd1);

        // Out-of-range index is rejected
        cfg_write(4'd4, 2'd0, 64'hDEAD_0000);
        chk("err_idx", 64'(cfg_err_o), 64'd1);
        run(1);
        chk("err_pulse_end", 64'(cfg_err_o), 64'd0);
        cfg_write(4'd15, 2'd2, 64'(5'b11111));
        chk("err_idx15", 64'(cfg_err_o), 64'd1);
        lookup(64'h8010_0000);
        expect_head(4'b0111, 1'b1, 4'd1);

`ifdef CULSANS_REGION_LOCK_EN
        cfg_write(4'd0, 2'd3, 64'd1);
        chk("lock_set", 64'(cfg_err_o), 64'd0);
        cfg_write(4'd1, 2'd0, 64'h0);
        chk("locked_write", 64'(cfg_err_o), 64'd1);
        lookup(64'h8010_0000);
        expect_head(4'b0111, 1'b1, 4'd1);
`else
        cfg_write(4'd0, 2'd3, 64'd1);
        chk("sel3_reject", 64'(cfg_err_o), 64'd1);
`endif

        // Reset with results in flight drops them and clears the table
        rsp_ready_i = 1'b0;
        lookup(64'h8010_0000);
        lookup(64'h8004_0000);
        #2;
        apply_reset();
        rsp_ready_i = 1'b1;
        cfg_write(4'd1, 2'd0, 64'h8000_0000);
        chk("post_reset_write", 64'(cfg_err_o), 64'd0);
        lookup(64'h8010_0000);
        expect_head(4'b1000, 1'b0, 4'd0);
        cfg_write(4'd1, 2'd1, 64'h4000_0000);
        cfg_write(4'd1, 2'd2, 64'(5'b11010));
        lookup(64'h8010_0000);
        expect_head(4'b1010, 1'b1, 4'd1);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            cfg_we_i  = ($urandom_range(0, 5) == 0);
            cfg_idx_i = 4'($urandom_range(0, 4));
            cfg_sel_i = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case (cfg_sel_i)
                2'd0:    cfg_wdata_i = 64'h8000_0000 + 64'($urandom_range(0, 7)) * 64'h1000;
                2'd1:    cfg_wdata_i = 64'($urandom_range(0, 3)) * 64'h800;
                2'd2:    cfg_wdata_i = 64'($urandom_range(0, 31));
                default: cfg_wdata_i = 64'($urandom_range(0, 1));
            endcase
            req_valid_i = ($urandom_range(0, 2) != 0);
            req_addr_i  = 64'h8000_0000 + 64'($urandom_range(0, 32'h9000));
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle();
        rsp_ready_i = 1'b1;
        run(4);
        chk("drained", 64'(rsp_valid_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
